// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared state encoding and round-robin channel search for the mux select scheduler.
package mux_sched_pkg;

    typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_e;

    // Lowest enabled index strictly after cur, wrapping at n; returns cur when nothing else is enabled.
    function automatic logic [3:0] next_ch(input logic [15:0] mask, input logic [3:0] cur, input int n);
        logic [3:0] res;
        logic [3:0] idx;
        res = cur;
        for (int i = 16; i >= 1; i--) begin
            idx = 4'((int'(cur) + i) % n);
            if (i <= n && mask[idx]) res = idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchronizer, stable-count debounce and one-cycle press pulse on a debounced fall.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse
);

    logic sync1_q, sync2_q, level_q, level_d, press_q, press_d, done;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        done    = sync2_q != level_q && cnt_q + 1'b1 == CNT_WIDTH'(DEBOUNCE_CYCLES);
        cnt_d   = (sync2_q == level_q || done) ? '0 : cnt_q + 1'b1;
        level_d = done ? sync2_q : level_q;
        press_d = done && !sync2_q;
    end

    // Button is active-low, so everything idles at the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign btn_level   = level_q;
    assign press_pulse = press_q;

endmodule

// File: rtl/mux_sel_scheduler.sv
// mux_sel_scheduler: registered channel select for an N-input mux, stepped by button presses or a dwell timer,
// skipping disabled channels.
module mux_sel_scheduler
    import mux_sched_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int SEL_WIDTH       = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DWELL_CYCLES    = 1000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 toggleButton,
    input  logic                 autoMode,
    input  logic                 hold,
    input  logic [NUM_CH-1:0]    chEnable,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 selChanged,
    output logic                 pressed
);

    logic unused_level, press, chg_q, forced, expired, adv;
    state_e state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d, nxt;
    logic [CNT_WIDTH-1:0] dwell_q, dwell_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (toggleButton),
        .btn_level  (unused_level),
        .press_pulse(press)
    );

    always_comb begin
        nxt     = SEL_WIDTH'(next_ch(16'(chEnable), 4'(sel_q), NUM_CH));
        forced  = !chEnable[sel_q] && |chEnable;
        expired = state_q == AUTO && dwell_q == CNT_WIDTH'(DWELL_CYCLES - 1);
        adv     = forced || (!hold && (press || expired));
        state_d = autoMode ? AUTO : MANUAL;
        sel_d   = adv ? nxt : sel_q;
        // Dwell only counts in AUTO; hold freezes it, advances and mode changes restart it.
        dwell_d = (state_d != state_q || adv || state_q == MANUAL) ? '0 :
                  hold ? dwell_q : dwell_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MANUAL;
            sel_q   <= '0;
            dwell_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            chg_q   <= sel_d != sel_q;
        end
    end

    assign sel        = sel_q;
    assign selChanged = chg_q;
    assign pressed    = press;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// tb_mux_sel_scheduler: directed stimulus with a select-change scoreboard for mux_sel_scheduler.
module tb_mux_sel_scheduler;

    logic       clk = 1'b0;
    logic       rst, toggleButton, autoMode, hold;
    logic [3:0] chEnable;
    logic [1:0] sel;
    logic       selChanged, pressed;

    int total = 0;
    int bad = 0;
    int press_cnt = 0;
    int base;
    int exp_q[$];

    always #5 clk = ~clk;

    mux_sel_scheduler #(
        .NUM_CH         (4),
        .SEL_WIDTH      (2),
        .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES   (10),
        .CNT_WIDTH      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .toggleButton(toggleButton),
        .autoMode    (autoMode),
        .hold        (hold),
        .chEnable    (chEnable),
        .sel         (sel),
        .selChanged  (selChanged),
        .pressed     (pressed)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(3);
        chk("rst_sel", int'(sel), 0);
        chk("rst_chg", int'(selChanged), 0);
        chk("rst_press", int'(pressed), 0);
        rst = 1'b1;
        cyc(2);
    endtask

    task automatic press_btn(input int e);
        exp_q.push_back(e);
        toggleButton = 1'b0;
        cyc(10);
        toggleButton = 1'b1;
        cyc(10);
    endtask

    // Every selChanged pulse must match the next queued select value.
    always @(negedge clk) begin
        if (rst) begin
            if (pressed) press_cnt++;
            if (selChanged) begin
                if (exp_q.size() == 0) chk("unexpected_change", int'(sel), -1);
                else chk("sel_change", int'(sel), exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0;
        toggleButton = 1'b1;
        autoMode = 1'b0;
        hold = 1'b0;
        chEnable = 4'hF;
        do_reset();

        exp_q.push_back(1);
        toggleButton = 1'b0;
        cyc(5);
        chk("t1_press_e5", int'(pressed), 0);
        chk("t1_sel_e5", int'(sel), 0);
        cyc(1);
        chk("t1_press_e6", int'(pressed), 1);
        chk("t1_sel_e6", int'(sel), 0);
        cyc(1);
        chk("t1_sel_e7", int'(sel), 1);
        chk("t1_chg_e7", int'(selChanged), 1);
        chk("t1_press_e7", int'(pressed), 0);
        cyc(1);
        chk("t1_chg_e8", int'(selChanged), 0);
        cyc(12);
        toggleButton = 1'b1;
        cyc(20);
        chk("t1_release_no_press", press_cnt, 1);
        chk("t1_sel_final", int'(sel), 1);

        do_reset();
        base = press_cnt;
        toggleButton = 1'b0;
        cyc(3);
        toggleButton = 1'b1;
        cyc(2);
        toggleButton = 1'b0;
        cyc(3);
        chk("bounce_no_press", press_cnt, base);
        chk("bounce_sel", int'(sel), 0);
        exp_q.push_back(1);
        cyc(6);
        toggleButton = 1'b1;
        cyc(12);
        chk("bounce_one_press", press_cnt, base + 1);
        chk("bounce_sel_after", int'(sel), 1);

        chEnable = 4'b1011;
        press_btn(3);
        press_btn(0);
        press_btn(1);
        chk("skip_wrap_sel", int'(sel), 1);
        chEnable = 4'hF;

        do_reset();
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        autoMode = 1'b1;
        cyc(10);
        chk("auto_e10", int'(sel), 0);
        cyc(1);
        chk("auto_e11", int'(sel), 1);
        chk("auto_chg_e11", int'(selChanged), 1);
        cyc(30);
        chk("auto_wrap", int'(sel), 0);
        exp_q.push_back(1);
        cyc(5);
        hold = 1'b1;
        cyc(8);
        hold = 1'b0;
        cyc(4);
        chk("hold_delay", int'(sel), 0);
        cyc(1);
        chk("hold_resume", int'(sel), 1);
        exp_q.push_back(2);
        cyc(3);
        toggleButton = 1'b0;
        cyc(6);
        chk("coincide_press", int'(pressed), 1);
        chk("coincide_sel_before", int'(sel), 1);
        cyc(1);
        chk("coincide_sel", int'(sel), 2);
        toggleButton = 1'b1;
        exp_q.push_back(3);
        cyc(1);
        chk("coincide_single", int'(sel), 2);
        cyc(9);
        chk("auto_after_coincide", int'(sel), 3);
        autoMode = 1'b0;
        cyc(20);
        chk("manual_no_scan", int'(sel), 3);

        do_reset();
        press_btn(1);
        press_btn(2);
        hold = 1'b1;
        exp_q.push_back(3);
        chEnable = 4'b1011;
        cyc(1);
        chk("forced_sel", int'(sel), 3);
        chk("forced_chg", int'(selChanged), 1);
        hold = 1'b0;
        chEnable = 4'b0000;
        cyc(50);
        chk("empty_mask_sel", int'(sel), 3);
        chk("empty_mask_chg", int'(selChanged), 0);

        chEnable = 4'hF;
        do_reset();
        base = press_cnt;
        toggleButton = 1'b0;
        cyc(4);
        rst = 1'b0;
        toggleButton = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(12);
        chk("midreset_no_press", press_cnt, base);
        chk("midreset_sel", int'(sel), 0);
        press_btn(1);
        chk("midreset_repress_sel", int'(sel), 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_scheduler.md
Name: mux_sel_scheduler

Overview:
Selection controller for the team's sequential data muxes. It debounces the raw toggle button and converts presses into one-cycle events. It generates the registered channel select for an N-input mux, in either manual (button-stepped) or auto-scan (dwell-timer) mode, skipping channels that are not enabled. It sits between the board button/mode inputs and the mux select input.

Parameters:
NUM_CH, 2, number of mux inputs (2..16)
SEL_WIDTH, 1, select width; must equal $clog2(NUM_CH)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button level change
DWELL_CYCLES, 1000, cycles spent on each channel in auto mode
CNT_WIDTH, 16, width of the debounce and dwell counters; must hold max(DEBOUNCE_CYCLES, DWELL_CYCLES)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset; asynchronous assert, active-low (0 = reset)
toggleButton  input  1  raw asynchronous button; pressed = 0
autoMode  input  1  1 = auto-scan, 0 = manual; synchronous level
hold  input  1  1 = suppress press and dwell advances
chEnable  input  NUM_CH  per-channel enable mask
sel  output  SEL_WIDTH  registered mux select
selChanged  output  1  one-cycle pulse, high in the first cycle sel shows a new value
pressed  output  1  one-cycle pulse per accepted button press

Behaviour:
- Reset (rst=0, asynchronous): sel=0, selChanged=0, pressed=0, debounced level=1 (released), counters=0, state=MANUAL. Outputs are valid on the first edge after release.
- Synchronizer: toggleButton passes through a 2-FF synchronizer before debounce.
- Debounce:
  - The counter runs while the synchronized level differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
- pressed: asserted for exactly one cycle on a debounced 1->0 transition. Releases (0->1) produce nothing.
- Press latency: 2 sync cycles + DEBOUNCE_CYCLES to pressed. sel updates on the next edge, and selChanged is high that same cycle.
- State machine:
  - States: MANUAL and AUTO.
  - MANUAL->AUTO when autoMode=1, sampled each cycle; AUTO->MANUAL when autoMode=0.
  - On entering AUTO, the dwell counter clears.
- Advance events:
  - MANUAL: pressed=1 and hold=0.
  - AUTO: (dwell counter == DWELL_CYCLES-1 or pressed=1) and hold=0.
  - Any advance or mode change clears the dwell counter.
  - The dwell counter is frozen while hold=1.
- Forced advance: if chEnable[sel]=0 and at least one channel is enabled, sel advances on the next edge regardless of hold or mode.
- Next channel: the lowest enabled index strictly after sel, searched round-robin with wrap past NUM_CH-1 to 0.
  - If the only enabled channel is sel, the advance is a no-op and selChanged stays 0.
  - If chEnable=0, sel holds, no selChanged, and the dwell counter still runs and wraps.
- Simultaneous press and dwell expiry in the same cycle: exactly one advance.
- Reset during debounce: the in-flight count is discarded and no press is emitted.
- selChanged never asserts without sel actually changing value.

Decomposition:
- Package mux_sched_pkg: state encoding (MANUAL=1'b0, AUTO=1'b1) and a next-enabled-channel function (mask, current) -> index, shared with the bench model.
- Sub-module button_debouncer: synchronizer + debounce counter + press pulse. Ports clk, rst, btn_raw, btn_level, press_pulse; parameters DEBOUNCE_CYCLES and CNT_WIDTH.

Test Plan:
Bench configuration: NUM_CH=4, SEL_WIDTH=2, DEBOUNCE_CYCLES=4, DWELL_CYCLES=10, chEnable=4'b1111 unless stated.
- Reset/clean press: rst low 3 cycles, then toggleButton 1->0 held 20 cycles -> sel=0 until pressed pulses at cycle 6 after the fall; sel=1 and selChanged=1 for one cycle at cycle 7; no event on release.
- Bounce rejection: toggleButton low for 3 cycles, high 2, low 3 -> no pressed, sel stays 0. Then hold low 6 cycles -> one press, sel=1.
- Skip and wrap: chEnable=4'b1011, sel=1, three presses -> sel sequence 3, 0, 1.
- Auto scan: autoMode=1 -> sel advances every 10 cycles (0,1,2,3,0). hold=1 at cycle 15 for 8 cycles -> dwell frozen and the next change is delayed by 8. Press coinciding with dwell expiry -> a single advance.
- Forced advance and empty mask: sel=2, chEnable 1111->1011 -> sel=3 next edge with selChanged. chEnable=0 -> sel stays 3, no selChanged for 50 cycles.
- Mid-debounce reset: toggleButton low, rst asserted at count 2 and released -> no pressed and sel=0. After re-press completes -> sel=1.
